sigmoid_stage: RTL

SIGMOID_STAGE -- requirements
Module: sigmoid_stage

---
 rtl/sigmoid_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/sigmoid_stage.sv
// rtl/sigmoid_stage.sv - piecewise-linear sigmoid stage with layer buffer and drain FSM
// Optional round-half-up quantization is enabled by defining SIG_ROUND_EN.
module sigmoid_stage #(
    parameter int N_NEURON = 40,
    parameter int ZFRAC    = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        z_valid,
    input  logic [31:0] z_in,
    output logic        z_ready,
    output logic        sig_valid,
    output logic [9:0]  sig_out,
    output logic [5:0]  sig_idx,
    input  logic        sig_ready,
    output logic        layer_done
);

    typedef enum logic [1:0] {IDLE, FILL, FLUSH, DRAIN} state_t;

    localparam logic [5:0]  LAST_IDX = 6'(N_NEURON - 1);
    localparam logic [30:0] A_FIVE   = 31'(5 << ZFRAC);
    localparam logic [30:0] A_KNEE   = 31'(19 << (ZFRAC - 3));
    localparam logic [30:0] A_ONE    = 31'(1 << ZFRAC);
    localparam logic signed [33:0] Y_ONE  = 34'sd1 <<< ZFRAC;
    localparam logic signed [33:0] Y_SEG2 = 34'sd27 <<< (ZFRAC - 5);
    localparam logic signed [33:0] Y_SEG1 = 34'sd5 <<< (ZFRAC - 3);
    localparam logic signed [33:0] Y_SEG0 = 34'sd1 <<< (ZFRAC - 1);
    localparam int QSH = ZFRAC - 10;

    state_t      state;
    logic [5:0]  cnt;
    logic        flush_cnt;
    logic        s1_valid;
    logic [30:0] s1_abs;
    logic        s1_neg;
    logic [1:0]  s1_seg;
    logic [5:0]  s1_idx;
    logic [9:0]  sig_buf [N_NEURON];

    logic [30:0] z_abs;
    logic [1:0]  z_seg;
    logic        z_fire;

    // Only 0x80000000 has bit 31 set with zero low bits; its magnitude saturates.
    always_comb begin
        z_abs = z_in[30:0];
        if (z_in[31])
            z_abs = (z_in[30:0] == 31'd0) ? 31'h7FFF_FFFF : (~z_in[30:0] + 31'd1);
        if (z_abs >= A_FIVE)
            z_seg = 2'd3;
        else if (z_abs >= A_KNEE)
            z_seg = 2'd2;
        else if (z_abs >= A_ONE)
            z_seg = 2'd1;
        else
            z_seg = 2'd0;
        z_fire = z_valid && z_ready;
    end

    logic [33:0]        a34;
    logic signed [33:0] y_pos;
    logic signed [33:0] y;
    logic signed [33:0] y_q;
    logic [9:0]         q10;

    always_comb begin
        a34 = {3'b000, s1_abs};
        case (s1_seg)
            2'd3:    y_pos = Y_ONE;
            2'd2:    y_pos = $signed(a34 >> 5) + Y_SEG2;
            2'd1:    y_pos = $signed(a34 >> 3) + Y_SEG1;
            default: y_pos = $signed(a34 >> 2) + Y_SEG0;
        endcase
        y = s1_neg ? (Y_ONE - y_pos) : y_pos;
`ifdef SIG_ROUND_EN
        y_q = y + (34'sd1 <<< (QSH - 1));
`else
        y_q = y;
`endif
        if (y_q < 0)
            q10 = 10'd0;
        else if (y_q >= Y_ONE)
            q10 = 10'h3FF;
        else
            q10 = 10'(y_q >>> QSH);
    end

    always_ff @(posedge clk) begin
        if (s1_valid)
            sig_buf[s1_idx] <= q10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 6'd0;
            flush_cnt  <= 1'b0;
            z_ready    <= 1'b1;
            sig_valid  <= 1'b0;
            sig_out    <= 10'd0;
            sig_idx    <= 6'd0;
            layer_done <= 1'b0;
            s1_valid   <= 1'b0;
            s1_abs     <= 31'd0;
            s1_neg     <= 1'b0;
            s1_seg     <= 2'd0;
            s1_idx     <= 6'd0;
        end else begin
            layer_done <= 1'b0;
            s1_valid   <= 1'b0;
            case (state)
                IDLE, FILL: begin
                    if (z_fire) begin
                        s1_valid <= 1'b1;
                        s1_abs   <= z_abs;
                        s1_neg   <= z_in[31];
                        s1_seg   <= z_seg;
                        s1_idx   <= cnt;
                        if (cnt == LAST_IDX) begin
                            cnt       <= 6'd0;
                            z_ready   <= 1'b0;
                            flush_cnt <= 1'b0;
                            state     <= FLUSH;
                        end else begin
                            cnt   <= cnt + 6'd1;
                            state <= FILL;
                        end
                    end
                end
                FLUSH: begin
                    // Second flush cycle: the last pipeline write has landed.
                    if (flush_cnt) begin
                        flush_cnt <= 1'b0;
                        sig_valid <= 1'b1;
                        sig_out   <= sig_buf[0];
                        sig_idx   <= 6'd0;
                        state     <= DRAIN;
                    end else begin
                        flush_cnt <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (sig_ready) begin
                        if (sig_idx == LAST_IDX) begin
                            sig_valid  <= 1'b0;
                            sig_idx    <= 6'd0;
                            layer_done <= 1'b1;
                            z_ready    <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            sig_idx <= sig_idx + 6'd1;
                            sig_out <= sig_buf[sig_idx + 6'd1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
